// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline control layout and constants
package mips_pkg;

  localparam int CTRL_W = 9;

  // Bit positions inside the decoded control bundle
  localparam int REG_WRITE  = 0;
  localparam int MEM_TO_REG = 1;
  localparam int MEM_READ   = 2;
  localparam int MEM_WRITE  = 3;
  localparam int ALU_SRC    = 4;
  localparam int REG_DST    = 5;
  localparam int ALU_OP_LO  = 6;
  localparam int ALU_OP_HI  = 8;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare
module hazard_detect
  import mips_pkg::*;
(
  input  logic       id_valid,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       hazard_stall
);

  // A load in EX whose destination feeds either ID source must stall one cycle.
  // The rt compare is deliberately conservative: I-type consumers match too.
  // Loads to $0 never produce a value, so they never stall.
  assign hazard_stall = id_valid & ex_valid & ex_mem_read & (ex_rt != REG_ZERO) &
                        ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = mips_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              flush,
  input  logic              ext_stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic              hazard_stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [CNT_W-1:0]  bubble_count
);
  import mips_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  hazard_detect u_hazard_detect (
    .id_valid     (id_valid),
    .ex_valid     (ex_valid),
    .ex_mem_read  (ex_ctrl[MEM_READ]),
    .ex_rt        (ex_rt),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .hazard_stall (hazard_stall)
  );

  // Front of the pipe freezes whenever this stage cannot accept the ID instruction
  assign pc_write    = ~(hazard_stall | ext_stall);
  assign if_id_write = ~(hazard_stall | ext_stall);

  // Pipeline register: flush > external hold > load-use bubble > normal load.
  // Bubbles zero controls and specifiers so nothing downstream acts or forwards
  // on them; data fields are left as-is since nothing consumes them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      ex_ctrl      <= '0;
      ex_pc4       <= '0;
      ex_rd1       <= '0;
      ex_rd2       <= '0;
      ex_imm       <= '0;
      ex_rs        <= REG_ZERO;
      ex_rt        <= REG_ZERO;
      ex_rd        <= REG_ZERO;
      bubble_count <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_rs    <= REG_ZERO;
      ex_rt    <= REG_ZERO;
      ex_rd    <= REG_ZERO;
    end else if (ext_stall) begin
      ex_valid <= ex_valid;
    end else if (hazard_stall) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_rs    <= REG_ZERO;
      ex_rt    <= REG_ZERO;
      ex_rd    <= REG_ZERO;
      if (bubble_count != CNT_MAX) begin
        bubble_count <= bubble_count + 1'b1;
      end
    end else begin
      ex_valid <= id_valid;
      ex_ctrl  <= id_ctrl;
      ex_pc4   <= id_pc4;
      ex_rd1   <= id_rd1;
      ex_rd2   <= id_rd2;
      ex_imm   <= id_imm;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
    end
  end

endmodule
